nes_multipad_reader: RTL

Parametrised serial game-pad reader polling up to CHANNELS NES/SNES-style pads that share one latch and one clock line, each pad having its own data line. It runs entirely in the system clock domain, using a clock-enable tick rather than a derived clock. It presents debounce-free, active-high button vectors plus sticky "newly pressed" flags to the I/O register block. It supersedes the fixed single-pad 16-bit reader.

---
 rtl/nes_multipad_reader_pkg.sv | 23 ++
 rtl/pad_tick_gen.sv | 39 +++
 rtl/nes_multipad_reader.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/nes_multipad_reader_pkg.sv
// Shared types and constants for the multi-pad serial reader.
package nes_pad_pkg;

    // Polling sequencer states; every transition happens on a half-period tick.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        LOW   = 2'd2,
        HIGH  = 2'd3
    } pad_state_e;

    // Number of half periods the latch line is held high.
    localparam int LATCH_HALVES = 2;

    // Legal parameter ranges.
    localparam int MIN_CHANNELS   = 1;
    localparam int MAX_CHANNELS   = 4;
    localparam int MIN_BITS       = 1;
    localparam int MAX_BITS       = 16;
    localparam int MIN_TICK_DIV   = 4;
    localparam int MIN_GAP_HALVES = 1;

endpackage

// File: rtl/pad_tick_gen.sv
// Free-running half-period timebase: one-cycle tick on the last cycle of
// every DIV-cycle half period, plus a last_cycle decode of the same point.
module pad_tick_gen #(
    parameter int DIV = 128
) (
    input  logic clk,
    input  logic resetn,
    output logic tick,
    output logic last_cycle
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;
    logic          tick_d;

    // Wrap the counter at DIV-1; the registered tick anticipates the wrap point.
    always_comb begin
        cnt_d  = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + 1'b1;
        tick_d = (cnt_d == CW'(DIV - 1));
    end

    // Counter and tick registers, restarted by reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick       = tick_q;
    assign last_cycle = (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/nes_multipad_reader.sv
// Polls up to four NES/SNES pads over a shared latch/clock pair and presents
// active-high button vectors with sticky newly-pressed flags.
module nes_multipad_reader
    import nes_pad_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int BITS       = 16,
    parameter int TICK_DIV   = 128,
    parameter int GAP_HALVES = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic                     clear_pressed,
    input  logic [CHANNELS-1:0]      pad_data,
    output logic                     pad_latch,
    output logic                     pad_clk,
    output logic [CHANNELS*BITS-1:0] buttons,
    output logic [CHANNELS*BITS-1:0] pressed,
    output logic                     frame_done
);

    localparam int W    = CHANNELS * BITS;
    localparam int MAXH = (GAP_HALVES > LATCH_HALVES) ? GAP_HALVES : LATCH_HALVES;
    localparam int HW   = $clog2(MAXH + 1);
    localparam int IW   = (BITS > 1) ? $clog2(BITS) : 1;

    if (CHANNELS < MIN_CHANNELS || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
        $error("nes_multipad_reader: CHANNELS out of range");
    end
    if (BITS < MIN_BITS || BITS > MAX_BITS) begin : g_bad_bits
        $error("nes_multipad_reader: BITS out of range");
    end
    if (TICK_DIV < MIN_TICK_DIV) begin : g_bad_div
        $error("nes_multipad_reader: TICK_DIV too small");
    end
    if (GAP_HALVES < MIN_GAP_HALVES) begin : g_bad_gap
        $error("nes_multipad_reader: GAP_HALVES too small");
    end

    logic tick;
    logic last_cycle;

    pad_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk        (clk),
        .resetn     (resetn),
        .tick       (tick),
        .last_cycle (last_cycle)
    );

    pad_state_e    state_q, state_d;
    logic [HW-1:0] half_q, half_d;
    logic [IW-1:0] idx_q, idx_d;

    logic          pad_latch_q, pad_latch_d;
    logic          pad_clk_q, pad_clk_d;
    logic [W-1:0]  buttons_q, buttons_d;
    logic [W-1:0]  pressed_q, pressed_d;
    logic          frame_done_q, frame_done_d;
    logic [W-1:0]  shift_all;
    logic [W-1:0]  new_btn;
    logic          frame_upd;

    // Per-pad synchronizer and capture register; bit idx is sampled at the
    // very end of each LOW half so the synchronized data has long settled.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [1:0]      sync_q, sync_d;
        logic [BITS-1:0] shift_q, shift_d;

        // Two-stage synchronizer shift and capture of the current bit.
        always_comb begin
            sync_d  = {sync_q[0], pad_data[gi]};
            shift_d = shift_q;
            if (state_q == LOW && last_cycle) begin
                shift_d[idx_q] = sync_q[1];
            end
        end

        // Synchronizer and shift register state.
        always_ff @(posedge clk) begin
            if (!resetn) begin
                sync_q  <= '0;
                shift_q <= '0;
            end else begin
                sync_q  <= sync_d;
                shift_q <= shift_d;
            end
        end

        assign shift_all[gi*BITS +: BITS] = shift_q;
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            half_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic: the gap counter saturates so a disabled reader
    // re-checks enable on every tick and latches as soon as it returns.
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        idx_d   = idx_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (half_q != HW'(GAP_HALVES)) begin
                        half_d = half_q + 1'b1;
                    end
                    if (enable && (half_q >= HW'(GAP_HALVES - 1))) begin
                        state_d = LATCH;
                        half_d  = '0;
                    end
                end
                LATCH: begin
                    if (half_q == HW'(LATCH_HALVES - 1)) begin
                        state_d = LOW;
                        half_d  = '0;
                        idx_d   = '0;
                    end else begin
                        half_d = half_q + 1'b1;
                    end
                end
                LOW: begin
                    state_d = HIGH;
                end
                HIGH: begin
                    if (idx_q == IW'(BITS - 1)) begin
                        state_d = IDLE;
                        half_d  = '0;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = LOW;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Pad-facing outputs follow the state being entered so they are registered.
    always_comb begin
        pad_latch_d = (state_d == LATCH);
        pad_clk_d   = (state_d != LOW);
    end

    // Frame update: all channels at once on the last HIGH tick; a new press
    // survives a coincident clear because it is ORed in after the clear.
    always_comb begin
        frame_upd    = (state_q == HIGH) && tick && (idx_q == IW'(BITS - 1));
        new_btn      = ~shift_all;
        buttons_d    = buttons_q;
        pressed_d    = clear_pressed ? '0 : pressed_q;
        frame_done_d = 1'b0;
        if (frame_upd) begin
            pressed_d    = pressed_d | (new_btn & ~buttons_q);
            buttons_d    = new_btn;
            frame_done_d = 1'b1;
        end
    end

    // Output registers; reset abandons any partial frame.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pad_latch_q  <= 1'b0;
            pad_clk_q    <= 1'b1;
            buttons_q    <= '0;
            pressed_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            pad_latch_q  <= pad_latch_d;
            pad_clk_q    <= pad_clk_d;
            buttons_q    <= buttons_d;
            pressed_q    <= pressed_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pad_latch  = pad_latch_q;
    assign pad_clk    = pad_clk_q;
    assign buttons    = buttons_q;
    assign pressed    = pressed_q;
    assign frame_done = frame_done_q;

endmodule
